spram_stream_loader: RTL
========================

# spram_stream_loader

Parametrised SPRAM loader: fetches a file region from the ESP over the "fread" request/response stream, packs bytes into 16-bit words, and fills one or more SB_SPRAM256KA banks. After loading, it serves registered reads to the application. It sits between the SPI fread bridge and user logic. Explicit chunk byte counting replaces the old pulse-width chunk heuristic.

## Interface
Parameters:
- NUM_BANKS, 1: SPRAM banks, 1..4, each 16384 x 16.
- LOAD_WORDS, 8192: words to load, 1..16384*NUM_BANKS.
- CHUNK_BYTES, 2048: bytes per fread request; even, ≥2.
- BASE_OFFSET, 32'h0: file offset of the first request.

Ports (AW = 14 + clog2(NUM_BANKS), minimum 14):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins or restarts loading.
- req_valid  out  1  fread request valid.
- req_ready  in  1  fread request accepted.
- req_offset  out  32  byte offset of the current request.
- resp_data  in  8  response byte.
- resp_valid  in  1  response byte valid; no backpressure.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  read word address.
- rd_data  out  16  read data.
- rd_valid  out  1  rd_data valid.
- busy  out  1  loading in progress.
- ram_ready  out  1  load complete; reads enabled.

## Operation
- States: IDLE, REQ, RECV, DONE.
- IDLE: on start, clear word_cnt, byte_cnt and the low-byte register; set req_offset=BASE_OFFSET; go to REQ.
- REQ: req_valid=1 with req_offset stable. When req_valid & req_ready, go to RECV. resp_valid in REQ is discarded.
- RECV: each resp_valid byte increments byte_cnt.
  - Even byte_cnt: byte is the low half; latch it.
  - Odd byte_cnt: byte is the high half; write {high,low} at word_cnt, then word_cnt+1.
- Chunk end: when byte_cnt reaches CHUNK_BYTES and word_cnt<LOAD_WORDS, set req_offset += CHUNK_BYTES (32-bit wrapping add), clear byte_cnt, go to REQ.
- Load end: when word_cnt reaches LOAD_WORDS, go to DONE. Any remaining bytes are discarded.
- DONE: ram_ready=1. Reads are serviced. start restarts via the IDLE actions.
- Bank select = word_address[AW-1:14]. Only the addressed bank gets WREN/CHIPSELECT. MASKWREN=4'b1111.
- Read bank select and output mux: driven from the registered bank index.
- Counters: word_cnt is AW+1 bits; byte_cnt is clog2(CHUNK_BYTES)+1 bits.
- rd_en outside DONE, or with rd_addr ≥ 16384*NUM_BANKS: ignored, rd_valid stays 0.
- start in REQ/RECV: ignored.

## Timing
- Reset values: req_valid=0, req_offset=BASE_OFFSET, rd_valid=0, rd_data=0 (mux output while rd_valid=0), busy=0, ram_ready=0, state IDLE.
- start at edge N: req_valid=1 from cycle N+1.
- Handshake: the request completes on the edge where req_valid & req_ready. req_valid=0 the next cycle.
- Write timing: high byte at edge N registers the write. The SPRAM write occurs at edge N+1. Back-to-back bytes every cycle are supported.
- Completion: ram_ready rises and busy falls one cycle after the final write is registered.
- Read latency: rd_en at edge N gives rd_data/rd_valid at cycle N+1. Fully pipelined, one read per cycle.
- Restart from DONE: ram_ready=0 from cycle N+1.
- rst mid-load: all outputs return to reset values next edge. SPRAM contents are undefined.

## Configuration
- SPRAM_LOADER_AUTOSTART_EN defined: the first cycle after rst deasserts acts as an implicit start pulse; the start port remains functional.
- Undefined: loading begins only on start.

## Structure
- Package spram_loader_pkg:
  - state enum {IDLE, REQ, RECV, DONE}.
  - SPRAM_DEPTH=16384, SPRAM_AW=14.
  - function for AW.
- Sub-module spram_bank: wraps one SB_SPRAM256KA with STANDBY=0, SLEEP=0, POWEROFF=1. Instantiated NUM_BANKS times in a generate loop.

## Test plan
- NUM_BANKS=1, LOAD_WORDS=8, CHUNK_BYTES=4, bytes 0x00..0x0F:
  - 4 requests at offsets 0,4,8,12.
  - Word0=0x0100, word7=0x0F0E.
  - ram_ready high; read addr 7 -> rd_data 0x0F0E one cycle later.
- req_ready held low 10 cycles: req_valid and req_offset stay stable; no write occurs; acceptance on cycle 11.
- NUM_BANKS=2, LOAD_WORDS=16386: words 16384/16385 land in bank 1. Read addr 16385 returns its pattern; addr 0 is unaffected.
- Extra bytes after the final word and resp_valid during REQ: no writes; word_cnt unchanged.
- rst asserted mid-RECV: next cycle req_valid=0, busy=0, ram_ready=0. A new start reloads from BASE_OFFSET.
- With SPRAM_LOADER_AUTOSTART_EN: req_valid rises 2 cycles after rst falls with no start pulse. Without it, req_valid stays 0.

Source files
------------

// File: rtl/spram_stream_loader_pkg.sv
// Shared types and geometry for the SPRAM stream loader.
package spram_loader_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    localparam int SPRAM_DEPTH = 16384;
    localparam int SPRAM_AW    = 14;

    // Word address width covering all banks; never narrower than one bank.
    function automatic int addr_width(input int num_banks);
        return (num_banks > 1) ? SPRAM_AW + $clog2(num_banks) : SPRAM_AW;
    endfunction

endpackage

// File: rtl/spram_stream_loader_if.sv
// Fread request/response stream, start control and read port of the SPRAM loader.
interface spram_stream_loader_if #(
    parameter int AW = 14
);
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_offset;
    logic [7:0]    resp_data;
    logic          resp_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic          busy;
    logic          ram_ready;

    modport master (
        input  start, req_ready, resp_data, resp_valid, rd_en, rd_addr,
        output req_valid, req_offset, rd_data, rd_valid, busy, ram_ready
    );

    modport slave (
        output start, req_ready, resp_data, resp_valid, rd_en, rd_addr,
        input  req_valid, req_offset, rd_data, rd_valid, busy, ram_ready
    );
endinterface

// File: rtl/spram_stream_loader_bank.sv
// One 16384 x 16 SPRAM bank: the iCE40 primitive in synthesis, a matching
// registered-read array model otherwise.
module spram_bank
    import spram_loader_pkg::*;
(
    input  logic                clk,
    input  logic                cs,
    input  logic                wren,
    input  logic [SPRAM_AW-1:0] addr,
    input  logic [15:0]         wdata,
    output logic [15:0]         rdata
);
`ifdef SYNTHESIS
    SB_SPRAM256KA u_spram (
        .ADDRESS    (addr),
        .DATAIN     (wdata),
        .MASKWREN   (4'b1111),
        .WREN       (wren),
        .CHIPSELECT (cs),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (rdata)
    );
`else
    logic [15:0] mem [SPRAM_DEPTH];
    logic [15:0] rdata_q;

    // Output holds its last value until the next selected read.
    always_ff @(posedge clk) begin
        if (cs) begin
            if (wren) mem[addr] <= wdata;
            else      rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;
`endif
endmodule

// File: rtl/spram_stream_loader.sv
// Loads a file region over the fread stream into SPRAM banks, then serves registered reads.
// Define SPRAM_LOADER_AUTOSTART_EN to start loading automatically once rst is released.
module spram_stream_loader
    import spram_loader_pkg::*;
#(
    parameter int          NUM_BANKS   = 1,
    parameter int          LOAD_WORDS  = 8192,
    parameter int          CHUNK_BYTES = 2048,
    parameter logic [31:0] BASE_OFFSET = 32'h0
) (
    input logic                   clk,
    input logic                   rst,
    spram_stream_loader_if.master bus
);
    localparam int AW  = addr_width(NUM_BANKS);
    localparam int WW  = AW + 1;
    localparam int BW  = $clog2(CHUNK_BYTES) + 1;
    localparam int BIW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [WW-1:0] LOAD_END  = WW'(LOAD_WORDS);
    localparam logic [WW-1:0] ADDR_LIM  = WW'(SPRAM_DEPTH * NUM_BANKS);
    localparam logic [BW-1:0] CHUNK_END = BW'(CHUNK_BYTES);

    function automatic logic [BIW-1:0] bank_of(input logic [AW-1:0] addr);
        logic [AW-1:0] upper;
        upper = addr >> SPRAM_AW;
        return BIW'(upper);
    endfunction

    state_t         state_q, state_d;
    logic           start_eff, start_ok;
    logic           byte_take, chunk_end, rd_hit;
    logic [WW-1:0]  word_cnt;
    logic [BW-1:0]  byte_cnt;
    logic [31:0]    req_offset_q;
    logic [7:0]     low_q;
    logic           wr_en_p1;
    logic [AW-1:0]  wr_addr_p1;
    logic [15:0]    wr_data_p1;
    logic           rd_vld_p1;
    logic [BIW-1:0] rd_bank_p1;
    logic [SPRAM_AW-1:0] bank_addr;
    logic [15:0]    bank_dout [NUM_BANKS];

`ifdef SPRAM_LOADER_AUTOSTART_EN
    logic auto_q;

    // High for exactly the first cycle after rst is released.
    always_ff @(posedge clk) auto_q <= rst;

    assign start_eff = bus.start | auto_q;
`else
    assign start_eff = bus.start;
`endif

    assign start_ok  = start_eff && (state_q == IDLE || state_q == DONE);
    // Bytes arriving once the chunk or the whole load is complete are dropped.
    assign byte_take = (state_q == RECV) && bus.resp_valid &&
                       (byte_cnt < CHUNK_END) && (word_cnt < LOAD_END);
    assign chunk_end = (state_q == RECV) && (byte_cnt == CHUNK_END) && (word_cnt < LOAD_END);
    assign rd_hit    = (state_q == DONE) && bus.rd_en && ({1'b0, bus.rd_addr} < ADDR_LIM);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_eff) state_d = REQ;
            REQ:     if (bus.req_ready) state_d = RECV;
            RECV: begin
                if (word_cnt >= LOAD_END) state_d = DONE;
                else if (chunk_end)       state_d = REQ;
            end
            DONE:    if (start_eff) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.ram_ready = 1'b0;
        case (state_q)
            REQ: begin
                bus.req_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            RECV:    bus.busy      = 1'b1;
            DONE:    bus.ram_ready = 1'b1;
            default: ;
        endcase
    end

    // p0 -> p1: counters, request offset and write/read strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt     <= '0;
            byte_cnt     <= '0;
            req_offset_q <= BASE_OFFSET;
            wr_en_p1     <= 1'b0;
            rd_vld_p1    <= 1'b0;
        end else begin
            wr_en_p1  <= byte_take && byte_cnt[0];
            rd_vld_p1 <= rd_hit;
            if (start_ok) begin
                word_cnt     <= '0;
                byte_cnt     <= '0;
                req_offset_q <= BASE_OFFSET;
            end else if (byte_take) begin
                byte_cnt <= byte_cnt + BW'(1);
                if (byte_cnt[0]) word_cnt <= word_cnt + WW'(1);
            end else if (chunk_end) begin
                byte_cnt     <= '0;
                req_offset_q <= req_offset_q + 32'(CHUNK_BYTES);
            end
        end
    end

    // p0 -> p1: byte packing and write/read datapath (unreset)
    always_ff @(posedge clk) begin
        if (start_ok)                       low_q <= '0;
        else if (byte_take && !byte_cnt[0]) low_q <= bus.resp_data;
        if (byte_take && byte_cnt[0]) begin
            wr_addr_p1 <= word_cnt[AW-1:0];
            wr_data_p1 <= {bus.resp_data, low_q};
        end
        if (rd_hit) rd_bank_p1 <= bank_of(bus.rd_addr);
    end

    // p1: SPRAM access; writes and reads never overlap since reads only run in DONE
    assign bank_addr = wr_en_p1 ? wr_addr_p1[SPRAM_AW-1:0] : bus.rd_addr[SPRAM_AW-1:0];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic wr_sel, rd_sel;

        assign wr_sel = wr_en_p1 && (bank_of(wr_addr_p1) == BIW'(b));
        assign rd_sel = rd_hit && (bank_of(bus.rd_addr) == BIW'(b));

        spram_bank u_bank (
            .clk   (clk),
            .cs    (wr_sel | rd_sel),
            .wren  (wr_sel),
            .addr  (bank_addr),
            .wdata (wr_data_p1),
            .rdata (bank_dout[b])
        );
    end

    assign bus.req_offset = req_offset_q;
    assign bus.rd_valid   = rd_vld_p1;
    assign bus.rd_data    = rd_vld_p1 ? bank_dout[rd_bank_p1] : 16'h0000;

endmodule
